// File: rtl/shift_register_universal_type_d_pkg.sv
// Shared definitions for the universal shift register: mode encodings.
package shift_register_universal_type_d_pkg;

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeShr  = 2'b01,
    ModeShl  = 2'b10,
    ModeLoad = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_register_universal_type_d_dff.sv
// One-bit D flip-flop with enable, asynchronous active-low reset and a reset value.
module shift_register_universal_type_d_dff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_L,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_register_universal_type_d.sv
// WIDTH-bit universal shift register: hold, shift right/left (optional rotate), parallel load,
// synchronous clear and a registered serial output.
module shift_register_universal_type_d
  import shift_register_universal_type_d_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             serial_r,
  input  logic             serial_l,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             serial_out
);

  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] d_vec;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] shl_vec;
  logic             shr_in;
  logic             shl_in;
  logic             so_q;
  logic             so_nxt;
  logic             so_d;
  logic             upd_en;

  // Clear must win even when enable is low, so it also opens the flop enables.
  assign upd_en  = enable | clear;
  assign shr_in  = rotate ? q_vec[0] : serial_r;
  assign shl_in  = rotate ? q_vec[WIDTH-1] : serial_l;
  assign shr_vec = {shr_in, q_vec[WIDTH-1:1]};
  assign shl_vec = {q_vec[WIDTH-2:0], shl_in};

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic nxt;

    always_comb begin
      nxt = q_vec[i];
      case (mode_e'(mode))
        ModeHold: nxt = q_vec[i];
        ModeShr:  nxt = shr_vec[i];
        ModeShl:  nxt = shl_vec[i];
        ModeLoad: nxt = D[i];
        default:  nxt = q_vec[i];
      endcase
    end

    assign d_vec[i] = clear ? RESET_VAL[i] : nxt;

    shift_register_universal_type_d_dff #(
      .RESET_VAL(RESET_VAL[i])
    ) u_stage (
      .clk    (clk),
      .reset_L(reset_L),
      .en     (upd_en),
      .d      (d_vec[i]),
      .q      (q_vec[i])
    );
  end

  always_comb begin
    so_nxt = so_q;
    case (mode_e'(mode))
      ModeShr: so_nxt = q_vec[0];
      ModeShl: so_nxt = q_vec[WIDTH-1];
      default: so_nxt = so_q;
    endcase
  end

  assign so_d = clear ? 1'b0 : so_nxt;

  shift_register_universal_type_d_dff #(
    .RESET_VAL(1'b0)
  ) u_serial_out (
    .clk    (clk),
    .reset_L(reset_L),
    .en     (upd_en),
    .d      (so_d),
    .q      (so_q)
  );

  assign Q          = q_vec;
  assign serial_out = so_q;

endmodule

// File: tb/tb_shift_register_universal_type_d.sv
// Self-checking bench: directed vector table, hand-written reset sequences, random vs. model.
module tb_shift_register_universal_type_d;

  logic       clk;
  logic       reset_L;
  logic       enable;
  logic       clear;
  logic [1:0] mode;
  logic       rotate;
  logic       serial_r;
  logic       serial_l;
  logic [7:0] D;
  logic [7:0] Q;
  logic       serial_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_q;
  logic       m_so;

  typedef struct {
    logic       clr;
    logic       en;
    logic [1:0] md;
    logic       rot;
    logic       sr;
    logic       sl;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic       exp_so;
  } vec_t;

  vec_t tbl[22];

  shift_register_universal_type_d #(
    .WIDTH    (8),
    .RESET_VAL(8'h00)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .enable    (enable),
    .clear     (clear),
    .mode      (mode),
    .rotate    (rotate),
    .serial_r  (serial_r),
    .serial_l  (serial_l),
    .D         (D),
    .Q         (Q),
    .serial_out(serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] exp_q, input logic exp_so);
    checks++;
    if (Q !== exp_q || serial_out !== exp_so) begin
      errors++;
      $display("FAIL %s: got Q=%h so=%b, expected Q=%h so=%b", name, Q, serial_out, exp_q,
               exp_so);
    end
  endtask

  // Reference model: arithmetic view of one clock edge.
  task automatic model_edge();
    logic [7:0] nq;
    logic       nso;
    nq  = m_q;
    nso = m_so;
    if (clear) begin
      nq  = 8'h00;
      nso = 1'b0;
    end else if (enable) begin
      if (mode == 2'd1) begin
        nso = m_q[0];
        nq  = (m_q >> 1) | ((rotate ? {7'd0, m_q[0]} : {7'd0, serial_r}) << 7);
      end else if (mode == 2'd2) begin
        nso = m_q[7];
        nq  = (m_q << 1) | (rotate ? {7'd0, m_q[7]} : {7'd0, serial_l});
      end else if (mode == 2'd3) begin
        nq = D;
      end
    end
    m_q  = nq;
    m_so = nso;
  endtask

  task automatic drive(input logic clr, input logic en, input logic [1:0] md, input logic rot,
                       input logic sr, input logic sl, input logic [7:0] d);
    clear    = clr;
    enable   = en;
    mode     = md;
    rotate   = rot;
    serial_r = sr;
    serial_l = sl;
    D        = d;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // clr en md rot sr sl d | exp_q exp_so
    tbl[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hD2, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hE9, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'h81, 8'h81, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h06, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h0C, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h18, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h30, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h60, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h81, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h2D, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h96, 1'b1};
    tbl[21] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h2C, 1'b1};

    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    reset_L = 1'b1;
    m_q     = 8'h00;
    m_so    = 1'b0;

    // Asynchronous reset between edges.
    @(negedge clk);
    #1 reset_L = 1'b0;
    #1 check("reset_async", 8'h00, 1'b0);
    @(negedge clk);
    check("reset_hold", 8'h00, 1'b0);
    reset_L = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i].clr, tbl[i].en, tbl[i].md, tbl[i].rot, tbl[i].sr, tbl[i].sl, tbl[i].d);
      step();
      check($sformatf("vec%0d", i), tbl[i].exp_q, tbl[i].exp_so);
    end

    // Reset mid shift-left sequence, then resume from zero.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 8'h0F);
    step();
    check("mid_load", 8'h0F, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'h00);
    step();
    check("mid_shl", 8'h1F, 1'b0);
    @(negedge clk);
    #1 reset_L = 1'b0;
    #1 check("mid_reset", 8'h00, 1'b0);
    #1 reset_L = 1'b1;
    m_q  = 8'h00;
    m_so = 1'b0;
    step();
    check("resume1", 8'h01, 1'b0);
    @(negedge clk);
    step();
    check("resume2", 8'h03, 1'b0);

    // Random stimulus against the model, with occasional async reset pulses.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom));
      if ($urandom_range(0, 24) == 0) begin
        #1 reset_L = 1'b0;
        #1 check("rand_reset", 8'h00, 1'b0);
        #1 reset_L = 1'b1;
        m_q  = 8'h00;
        m_so = 1'b0;
      end
      step();
      check($sformatf("rand%0d", n), m_q, m_so);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
